// File: rtl/edge_latency_checker_if.sv
// Stimulus/response monitor bus: bench-driven chain signals in, measurement and error flags out.
interface edge_latency_checker_if #(parameter int CNT_W = 8);
  logic             stim, resp, clear_err;
  logic             busy, lat_valid, fatal;
  logic [CNT_W-1:0] lat, edge_count;
  logic             err_timeout, err_spurious, err_polarity, err_overrun;

  modport slave (
    input  stim, resp, clear_err,
    output busy, lat_valid, lat, edge_count, fatal,
           err_timeout, err_spurious, err_polarity, err_overrun
  );
  modport master (
    output stim, resp, clear_err,
    input  busy, lat_valid, lat, edge_count, fatal,
           err_timeout, err_spurious, err_polarity, err_overrun
  );
endinterface

// File: rtl/edge_latency_checker.sv
// Pairs each stim edge with one resp edge of the expected level within MAX_LAT clocks,
// reports latency and raises sticky timeout/spurious/polarity/overrun errors.
module edge_latency_checker #(
  parameter bit INVERTING   = 1'b1,
  parameter int MAX_LAT     = 8,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  edge_latency_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PEND, HALT} state_t;

  state_t           state, nxt;
  logic             stim_q, resp_q, exp_q;
  logic [CNT_W-1:0] cnt, lat, edge_count, match_lat;
  logic             busy, lat_valid, fatal;
  logic             err_to, err_sp, err_po, err_ov;
  logic             s_edge, r_edge, exp_new;
  logic             match, load, inc, e_to, e_sp, e_po, e_ov, any_err;

  assign s_edge  = bus.stim ^ stim_q;
  assign r_edge  = bus.resp ^ resp_q;
  assign exp_new = bus.stim ^ INVERTING;

  always_comb begin
    nxt       = state;
    match     = 1'b0;
    match_lat = '0;
    load      = 1'b0;
    inc       = 1'b0;
    e_to      = 1'b0;
    e_sp      = 1'b0;
    e_po      = 1'b0;
    e_ov      = 1'b0;
    case (state)
      IDLE: begin
        if (s_edge && r_edge) begin
          // chain with zero clock delay: judge resp against the stim it arrived with
          if (bus.resp == exp_new) match = 1'b1;
          else                     e_po  = 1'b1;
        end else if (s_edge) begin
          load = 1'b1;
          nxt  = PEND;
        end else if (r_edge) begin
          e_sp = 1'b1;
        end
      end
      PEND: begin
        if (r_edge) begin
          if (bus.resp == exp_q) begin
            match     = 1'b1;
            match_lat = cnt;
          end else begin
            e_po = 1'b1;
          end
          if (s_edge) load = 1'b1;
          else        nxt  = IDLE;
        end else if (s_edge) begin
          e_ov = 1'b1;
          load = 1'b1;
        end else if (cnt == CNT_W'(MAX_LAT)) begin
          e_to = 1'b1;
          nxt  = IDLE;
        end else begin
          inc = 1'b1;
        end
      end
      default: if (bus.clear_err) nxt = IDLE;
    endcase
    any_err = e_to | e_sp | e_po | e_ov;
    if (any_err && STOP_ON_ERR) nxt = HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stim_q     <= bus.stim;
      resp_q     <= bus.resp;
      exp_q      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      lat        <= '0;
      edge_count <= '0;
      busy       <= 1'b0;
      lat_valid  <= 1'b0;
      fatal      <= 1'b0;
      err_to     <= 1'b0;
      err_sp     <= 1'b0;
      err_po     <= 1'b0;
      err_ov     <= 1'b0;
    end else begin
      stim_q    <= bus.stim;
      resp_q    <= bus.resp;
      state     <= nxt;
      busy      <= (nxt == PEND);
      lat_valid <= match;
      fatal     <= any_err;
      if (match) begin
        lat        <= match_lat;
        edge_count <= edge_count + CNT_W'(1);
      end
      if (load) begin
        cnt   <= CNT_W'(1);
        exp_q <= exp_new;
      end else if (inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      // a fresh error in the clearing cycle survives the clear
      err_to <= e_to | (err_to & ~bus.clear_err);
      err_sp <= e_sp | (err_sp & ~bus.clear_err);
      err_po <= e_po | (err_po & ~bus.clear_err);
      err_ov <= e_ov | (err_ov & ~bus.clear_err);
    end
  end

  assign bus.busy         = busy;
  assign bus.lat_valid    = lat_valid;
  assign bus.lat          = lat;
  assign bus.edge_count   = edge_count;
  assign bus.fatal        = fatal;
  assign bus.err_timeout  = err_to;
  assign bus.err_spurious = err_sp;
  assign bus.err_polarity = err_po;
  assign bus.err_overrun  = err_ov;
endmodule
